tile_mem: RTL and testbench

Parametrised wide-line tile memory serving the systolic wrapper's three memory channels: W read, X read and output write. It replaces the single-cycle behavioural memory previously used around the wrapper with synthesizable RTL. New capabilities:

- configurable line width and depth
- configurable read latency
- per-lane write strobes
- selectable same-cycle write/read collision policy
- out-of-range error reporting
- saturating access counters

---
 rtl/tile_mem_if.sv | 40 ++++
 rtl/tile_mem.sv | 144 ++++++++++++++
 tb/tb_tile_mem.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_mem_if.sv
// Bus bundle for tile_mem: W and X read channels, the write channel and status.
// The master drives requests; the slave (the memory) returns data and status.
interface tile_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 32
);
  localparam int LW = DATA_WIDTH * LANES;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  mem_read_w;
  logic [LW-1:0]         w_rdata;
  logic                  w_rvalid;

  logic [ADDR_WIDTH-1:0] x_addr;
  logic                  mem_read_x;
  logic [LW-1:0]         x_rdata;
  logic                  x_rvalid;

  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic                  mem_write;
  logic [LW-1:0]         mem_wdata;
  logic [LANES-1:0]      mem_wstrb;

  logic                  err;
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;

  modport master (
    output w_addr, mem_read_w, x_addr, mem_read_x,
           mem_write_addr, mem_write, mem_wdata, mem_wstrb,
    input  w_rdata, w_rvalid, x_rdata, x_rvalid, err, rd_count, wr_count
  );

  modport slave (
    input  w_addr, mem_read_w, x_addr, mem_read_x,
           mem_write_addr, mem_write, mem_wdata, mem_wstrb,
    output w_rdata, w_rvalid, x_rdata, x_rvalid, err, rd_count, wr_count
  );
endinterface

// File: rtl/tile_mem.sv
// Wide-line tile memory with two read ports (W, X) and one lane-strobed write port.
// Reads are captured at issue and delivered through a fixed RD_LATENCY pipeline.
module tile_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 4,
  parameter int DEPTH       = 32,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic      clk,
  input  logic      rst,
  tile_mem_if.slave bus
);
  localparam int LW   = DATA_WIDTH * LANES;
  localparam int OFFS = $clog2(LW / 8);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef logic [LW-1:0] line_t;

  line_t                 mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  wr_in_range;
  logic                  wr_en;
  line_t                 wr_mask;

  logic [ADDR_WIDTH-1:0] rd_idx   [2];
  logic                  rd_req   [2];
  logic                  rd_ok    [2];
  line_t                 rd_data  [2];

  line_t                 rd_pipe  [2][RD_LATENCY];
  logic                  rd_vld   [2][RD_LATENCY];

  logic [15:0]           rd_count_q;
  logic [15:0]           wr_count_q;
  logic                  err_q;
  logic [1:0]            rd_inc;
  logic [16:0]           rd_sum;
  logic                  oob;

  // Byte-offset bits are dropped, so misaligned addresses alias to their line.
  assign wr_idx      = bus.mem_write_addr >> OFFS;
  assign wr_in_range = wr_idx < DEPTH_A;
  assign wr_en       = bus.mem_write && wr_in_range;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_mask[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{bus.mem_wstrb[k]}};
    end
  end

  // Issue-time read data; WRITE_FIRST forwards strobed lanes of a colliding write.
  always_comb begin
    line_t v;
    rd_req[0] = bus.mem_read_w;
    rd_req[1] = bus.mem_read_x;
    rd_idx[0] = bus.w_addr >> OFFS;
    rd_idx[1] = bus.x_addr >> OFFS;
    for (int p = 0; p < 2; p++) begin
      rd_ok[p] = rd_idx[p] < DEPTH_A;
      v = '0;
      if (rd_ok[p]) begin
        v = mem[rd_idx[p][IW-1:0]];
        if (WRITE_FIRST != 0 && wr_en && rd_idx[p] == wr_idx) begin
          v = (v & ~wr_mask) | (bus.mem_wdata & wr_mask);
        end
      end
      rd_data[p] = v;
    end
  end

  // NOTE: the storage array has no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.mem_wstrb[k]) begin
          mem[wr_idx[IW-1:0]][k*DATA_WIDTH +: DATA_WIDTH] <=
            bus.mem_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Data stages load only behind a valid, so the last stage holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < RD_LATENCY; s++) begin
          rd_vld[p][s]  <= 1'b0;
          rd_pipe[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rd_vld[p][0] <= rd_req[p];
        if (rd_req[p]) begin
          rd_pipe[p][0] <= rd_data[p];
        end
        for (int s = 1; s < RD_LATENCY; s++) begin
          rd_vld[p][s] <= rd_vld[p][s-1];
          if (rd_vld[p][s-1]) begin
            rd_pipe[p][s] <= rd_pipe[p][s-1];
          end
        end
      end
    end
  end

  assign rd_inc = {1'b0, bus.mem_read_w} + {1'b0, bus.mem_read_x};
  assign rd_sum = {1'b0, rd_count_q} + {15'd0, rd_inc};
  assign oob    = (bus.mem_read_w && !rd_ok[0]) ||
                  (bus.mem_read_x && !rd_ok[1]) ||
                  (bus.mem_write  && !wr_in_range);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_count_q <= rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
      if (wr_en && wr_count_q != 16'hFFFF) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (oob) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.w_rdata  = rd_pipe[0][RD_LATENCY-1];
  assign bus.w_rvalid = rd_vld[0][RD_LATENCY-1];
  assign bus.x_rdata  = rd_pipe[1][RD_LATENCY-1];
  assign bus.x_rvalid = rd_vld[1][RD_LATENCY-1];
  assign bus.err      = err_q;
  assign bus.rd_count = rd_count_q;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_tile_mem.sv
// Drives five tile_mem instances (RD_LATENCY 1..4, both collision policies) with
// identical stimulus and checks them against a line-level behavioural model.
module tb_tile_mem;
  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 32;
  localparam int NDUT  = 5;
  localparam int LW    = DW * LANES;
  localparam int OFFS  = $clog2(LW / 8);

  typedef logic [LW-1:0] line_t;
  typedef struct packed { logic [31:0] stamp; line_t data; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]    s_w_addr = '0, s_x_addr = '0, s_wr_addr = '0;
  logic             s_rd_w = 1'b0, s_rd_x = 1'b0, s_wr = 1'b0;
  line_t            s_wdata = '0;
  logic [LANES-1:0] s_wstrb = '0;

  logic        o_wv [NDUT];
  logic        o_xv [NDUT];
  logic        o_err[NDUT];
  line_t       o_wd [NDUT];
  line_t       o_xd [NDUT];
  logic [15:0] o_rc [NDUT];
  logic [15:0] o_wc [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tile_mem_if #(.DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW)) bus ();
    assign bus.w_addr         = s_w_addr;
    assign bus.mem_read_w     = s_rd_w;
    assign bus.x_addr         = s_x_addr;
    assign bus.mem_read_x     = s_rd_x;
    assign bus.mem_write_addr = s_wr_addr;
    assign bus.mem_write      = s_wr;
    assign bus.mem_wdata      = s_wdata;
    assign bus.mem_wstrb      = s_wstrb;
    assign o_wv[g]  = bus.w_rvalid;
    assign o_xv[g]  = bus.x_rvalid;
    assign o_wd[g]  = bus.w_rdata;
    assign o_xd[g]  = bus.x_rdata;
    assign o_err[g] = bus.err;
    assign o_rc[g]  = bus.rd_count;
    assign o_wc[g]  = bus.wr_count;

    tile_mem #(
      .DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH),
      .RD_LATENCY(g % 4 + 1), .WRITE_FIRST(g % 2), .ADDR_WIDTH(AW)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  // Reference model state
  line_t       ref_mem [DEPTH];
  int unsigned cyc   = 0;
  int unsigned m_rc  = 0;
  int unsigned m_wc  = 0;
  logic        m_err = 1'b0;
  bit          track = 1'b1;
  rsp_t        exp_q [NDUT][2][$];
  int          total = 0;
  int          bad   = 0;

  function automatic int lat_of(int d);
    return d % 4 + 1;
  endfunction

  function automatic bit wf_of(int d);
    return (d % 2) == 1;
  endfunction

  function automatic line_t merged(line_t old, line_t nw, logic [LANES-1:0] st);
    line_t r = old;
    for (int k = 0; k < LANES; k++) if (st[k]) r[k*DW +: DW] = nw[k*DW +: DW];
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr(int unsigned hi);
    return AW'(($urandom_range(0, hi) << OFFS) | $urandom_range(0, (1 << OFFS) - 1));
  endfunction

  // Applies the current stimulus to the model, then advances one clock.
  task automatic step();
    int unsigned ri, wi;
    logic [AW-1:0] a;
    line_t pre, post;
    rsp_t e;
    if (!rst) begin
      wi = s_wr_addr >> OFFS;
      for (int p = 0; p < 2; p++) begin
        a = (p == 1) ? s_x_addr : s_w_addr;
        if ((p == 1) ? s_rd_x : s_rd_w) begin
          ri = a >> OFFS;
          if (ri < DEPTH) pre = ref_mem[ri];
          else pre = '0;
          post = pre;
          if (ri < DEPTH && s_wr && wi == ri) post = merged(pre, s_wdata, s_wstrb);
          if (ri >= DEPTH) m_err = 1'b1;
          m_rc = (m_rc < 65535) ? m_rc + 1 : 65535;
          if (track) begin
            for (int d = 0; d < NDUT; d++) begin
              e.stamp = cyc + lat_of(d);
              e.data  = wf_of(d) ? post : pre;
              exp_q[d][p].push_back(e);
            end
          end
        end
      end
      if (s_wr) begin
        if (wi < DEPTH) begin
          ref_mem[wi] = merged(ref_mem[wi], s_wdata, s_wstrb);
          m_wc = (m_wc < 65535) ? m_wc + 1 : 65535;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    s_rd_w = 1'b0; s_rd_x = 1'b0; s_wr = 1'b0; s_wstrb = '0;
  endtask

  task automatic idle(int n);
    clear();
    repeat (n) step();
  endtask

  task automatic wr_line(int unsigned idx, line_t d, logic [LANES-1:0] st);
    s_wr = 1'b1; s_wr_addr = AW'(idx << OFFS); s_wdata = d; s_wstrb = st;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) for (int p = 0; p < 2; p++) exp_q[d][p].delete();
    m_rc = 0; m_wc = 0; m_err = 1'b0;
    repeat (n) step();
    clear();
    rst = 1'b0;
  endtask

  // Read-response checker: every rvalid must match the next expected response in time and data.
  always @(negedge clk) begin : mon
    logic  v;
    line_t dat;
    rsp_t  e;
    if (track) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int p = 0; p < 2; p++) begin
          v   = (p == 1) ? o_xv[d] : o_wv[d];
          dat = (p == 1) ? o_xd[d] : o_wd[d];
          while (exp_q[d][p].size() > 0 && exp_q[d][p][0].stamp < cyc) begin
            e = exp_q[d][p].pop_front();
            total++; bad++;
            $display("FAIL rsp_lost dut%0d port%0d: response due at cycle %0d never checked", d, p, e.stamp);
          end
          if (exp_q[d][p].size() > 0 && exp_q[d][p][0].stamp == cyc) begin
            e = exp_q[d][p].pop_front();
            total++;
            if (v !== 1'b1 || dat !== e.data) begin
              bad++;
              $display("FAIL rsp dut%0d port%0d cyc=%0d: got valid=%b data=%h, required valid=1 data=%h",
                       d, p, cyc, v, dat, e.data);
            end
          end else if (v !== 1'b0) begin
            total++; bad++;
            $display("FAIL spurious_rvalid dut%0d port%0d cyc=%0d: got valid=%b, required 0", d, p, cyc, v);
          end
        end
      end
    end
  end

  task automatic test_reset();
    line_t l3 = {32'd4, 32'd3, 32'd2, 32'd1};
    do_reset(2);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if ({o_wv[d], o_xv[d], o_err[d]} !== 3'b000 || o_wd[d] !== '0 || o_xd[d] !== '0 ||
          o_rc[d] !== 16'd0 || o_wc[d] !== 16'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got wv=%b xv=%b err=%b wd=%h xd=%h rc=%h wc=%h, required all 0",
                 d, o_wv[d], o_xv[d], o_err[d], o_wd[d], o_xd[d], o_rc[d], o_wc[d]);
      end
    end
    clear(); wr_line(3, l3, 4'hF); step();
    clear(); s_rd_w = 1'b1; s_w_addr = 32'h30; step();
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_rc[d] !== 16'd1 || o_wc[d] !== 16'd1) begin
        bad++;
        $display("FAIL first_counts dut%0d: got rc=%h wc=%h, required rc=1 wc=1", d, o_rc[d], o_wc[d]);
      end
    end
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_wd[d] !== l3) begin
        bad++;
        $display("FAIL first_read_hold dut%0d: got %h, required %h", d, o_wd[d], l3);
      end
    end
  endtask

  task automatic test_partial_write();
    line_t want = {32'hA, 32'd9, 32'hC, 32'd9};
    clear(); wr_line(5, {32'hA, 32'hB, 32'hC, 32'hD}, 4'hF); step();
    clear(); wr_line(5, {4{32'd9}}, 4'b0101); step();
    clear(); s_rd_x = 1'b1; s_x_addr = 32'h50; step();
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_xd[d] !== want) begin
        bad++;
        $display("FAIL partial_write dut%0d: got %h, required %h", d, o_xd[d], want);
      end
    end
  endtask

  task automatic test_collision();
    line_t want;
    clear(); wr_line(7, {4{32'd1}}, 4'hF); step();
    clear(); wr_line(7, {4{32'd2}}, 4'hF); s_rd_w = 1'b1; s_w_addr = 32'h70; step();
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      want = wf_of(d) ? {4{32'd2}} : {4{32'd1}};
      total++;
      if (o_wd[d] !== want) begin
        bad++;
        $display("FAIL collision dut%0d wf=%0d: got %h, required %h", d, wf_of(d), o_wd[d], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned rc0;
    for (int i = 0; i < 8; i++) begin
      clear(); wr_line(i, {$urandom, $urandom, $urandom, $urandom}, 4'hF); step();
    end
    rc0 = m_rc;
    for (int i = 0; i < 8; i++) begin
      clear();
      s_rd_w = 1'b1; s_w_addr = AW'((i << OFFS) | $urandom_range(0, 15));
      s_rd_x = 1'b1; s_x_addr = AW'(((7 - i) << OFFS) | $urandom_range(0, 15));
      step();
    end
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_rc[d] !== 16'(rc0 + 16)) begin
        bad++;
        $display("FAIL b2b_rd_count dut%0d: got %h, required %h", d, o_rc[d], 16'(rc0 + 16));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) begin
      clear(); wr_line(i, {$urandom, $urandom, $urandom, $urandom}, 4'hF); step();
    end
    for (int n = 0; n < 300; n++) begin
      clear();
      s_rd_w = 1'($urandom_range(0, 1)); s_w_addr = rand_addr(7);
      s_rd_x = 1'($urandom_range(0, 1)); s_x_addr = rand_addr(7);
      s_wr = 1'($urandom_range(0, 1)); s_wr_addr = rand_addr(7);
      s_wdata = {$urandom, $urandom, $urandom, $urandom};
      s_wstrb = 4'($urandom);
      step();
    end
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_rc[d] !== 16'(m_rc) || o_wc[d] !== 16'(m_wc) || o_err[d] !== m_err) begin
        bad++;
        $display("FAIL random_status dut%0d: got rc=%h wc=%h err=%b, required rc=%h wc=%h err=%b",
                 d, o_rc[d], o_wc[d], o_err[d], 16'(m_rc), 16'(m_wc), m_err);
      end
    end
  endtask

  task automatic test_error();
    int unsigned wc0 = m_wc;
    line_t keep = ref_mem[8];
    clear(); s_rd_w = 1'b1; s_w_addr = 32'h200; wr_line(40, '1, 4'hF); step();
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_err[d] !== 1'b1 || o_wc[d] !== 16'(wc0)) begin
        bad++;
        $display("FAIL oob_status dut%0d: got err=%b wc=%h, required err=1 wc=%h", d, o_err[d], o_wc[d], 16'(wc0));
      end
    end
    clear(); s_rd_x = 1'b1; s_x_addr = AW'(8 << OFFS); step();
    idle(8);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_wd[d] !== '0 || o_xd[d] !== keep || o_err[d] !== 1'b1) begin
        bad++;
        $display("FAIL oob_after dut%0d: got wd=%h xd=%h err=%b, required wd=0 xd=%h err=1",
                 d, o_wd[d], o_xd[d], o_err[d], keep);
      end
    end
  endtask

  task automatic test_reset_mid();
    line_t l3 = ref_mem[3];
    for (int i = 0; i < 3; i++) begin
      clear();
      s_rd_w = 1'b1; s_w_addr = AW'(i << OFFS);
      s_rd_x = 1'b1; s_x_addr = AW'((i + 3) << OFFS);
      step();
    end
    clear(); wr_line(3, ~l3, 4'hF); s_rd_w = 1'b1; s_w_addr = 32'h30;
    do_reset(2);
    idle(6);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_err[d] !== 1'b0 || o_rc[d] !== 16'd0 || o_wc[d] !== 16'd0) begin
        bad++;
        $display("FAIL midreset_status dut%0d: got err=%b rc=%h wc=%h, required all 0", d, o_err[d], o_rc[d], o_wc[d]);
      end
    end
    clear(); s_rd_w = 1'b1; s_w_addr = 32'h30; step();
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_wd[d] !== l3) begin
        bad++;
        $display("FAIL midreset_write_dropped dut%0d: got %h, required %h", d, o_wd[d], l3);
      end
    end
  endtask

  task automatic test_saturation();
    track = 1'b0;
    while (m_rc < 65534) begin
      clear();
      s_rd_w = 1'b1; s_w_addr = '0;
      if (65534 - m_rc >= 2) begin
        s_rd_x = 1'b1; s_x_addr = 32'h10;
      end
      step();
    end
    idle(6);
    track = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (o_rc[d] !== 16'hFFFE) begin
        bad++;
        $display("FAIL sat_preload dut%0d: got %h, required fffe", d, o_rc[d]);
      end
    end
    for (int r = 0; r < 2; r++) begin
      clear(); s_rd_w = 1'b1; s_w_addr = '0; s_rd_x = 1'b1; s_x_addr = 32'h10; step();
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if (o_rc[d] !== 16'hFFFF) begin
          bad++;
          $display("FAIL sat_dual_read%0d dut%0d: got %h, required ffff", r, d, o_rc[d]);
        end
      end
    end
    idle(5);
  endtask

  initial begin
    test_reset();
    test_partial_write();
    test_collision();
    test_back_to_back();
    test_random();
    test_error();
    test_reset_mid();
    test_saturation();
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (exp_q[d][0].size() + exp_q[d][1].size() != 0) begin
        bad++;
        $display("FAIL pending_rsp dut%0d: got %0d outstanding, required 0", d,
                 exp_q[d][0].size() + exp_q[d][1].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
